// File: rtl/msf_pkg.sv
// MSF time-code constants, snapshot layout and FSM state type.
// Purely declarative: no logic, no latency.
// Shared by the encoder top and the frame-bit mapper.
package msf_pkg;

  localparam int SEGS_PER_SEC = 10;
  localparam int SECS_PER_MIN = 60;
  localparam int MARKER_SEGS  = 5;

  // A-bit field positions (first second of each field) and widths, MSB first
  localparam int YEAR_POS  = 17;
  localparam int YEAR_W    = 8;
  localparam int MONTH_POS = 25;
  localparam int MONTH_W   = 5;
  localparam int DAY_POS   = 30;
  localparam int DAY_W     = 6;
  localparam int DOW_POS   = 36;
  localparam int DOW_W     = 3;
  localparam int HOUR_POS  = 39;
  localparam int HOUR_W    = 6;
  localparam int MIN_POS   = 45;
  localparam int MIN_W     = 7;
  localparam int PAT_POS   = 52;
  localparam int PAT_W     = 8;

  localparam logic [PAT_W-1:0] A_PATTERN = 8'b0111_1110;

  // B-bit positions that carry information
  localparam int B_PAR_YEAR = 54;
  localparam int B_PAR_DATE = 55;
  localparam int B_PAR_DOW  = 56;
  localparam int B_PAR_TIME = 57;
  localparam int B_BST      = 58;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
    logic [DOW_W-1:0]   dow;
    logic [HOUR_W-1:0]  hour;
    logic [MIN_W-1:0]   minute;
    logic               bst;
  } snap_t;

endpackage

// File: rtl/msf_encoder_if.sv
// Control, date/time and keying signals of the MSF encoder.
// No storage, no latency.
// The driver owns the inputs; the encoder never stalls them.
interface msf_encoder_if;
  logic       tick_ms_i;
  logic       start_i;
  logic       stop_i;
  logic [7:0] year_i;
  logic [4:0] month_i;
  logic [5:0] day_i;
  logic [2:0] dow_i;
  logic [5:0] hour_i;
  logic [6:0] minute_i;
  logic       bst_i;
  logic       carrier_o;
  logic [5:0] second_o;
  logic       minute_start_o;
  logic       busy_o;

  modport master (
    output tick_ms_i, start_i, stop_i, year_i, month_i, day_i, dow_i,
           hour_i, minute_i, bst_i,
    input  carrier_o, second_o, minute_start_o, busy_o
  );

  modport slave (
    input  tick_ms_i, start_i, stop_i, year_i, month_i, day_i, dow_i,
           hour_i, minute_i, bst_i,
    output carrier_o, second_o, minute_start_o, busy_o
  );
endinterface

// File: rtl/msf_frame_bits.sv
// Maps (second, snapshot) to the MSF A and B bits of that second.
// Combinational, zero latency.
// No flow control.
module msf_frame_bits
  import msf_pkg::*;
(
  input  logic [5:0] second,
  input  snap_t      snap,
  output logic       a_bit,
  output logic       b_bit
);

  // Ascending ranges so that a field's MSB lands on its lowest second
  logic [0:63] a_vec;
  logic [0:63] b_vec;

  // Assemble the whole minute's A and B bit strings, including parity trees
  always_comb begin
    a_vec = '0;
    b_vec = '0;
    a_vec[YEAR_POS  +: YEAR_W]  = snap.year;
    a_vec[MONTH_POS +: MONTH_W] = snap.month;
    a_vec[DAY_POS   +: DAY_W]   = snap.day;
    a_vec[DOW_POS   +: DOW_W]   = snap.dow;
    a_vec[HOUR_POS  +: HOUR_W]  = snap.hour;
    a_vec[MIN_POS   +: MIN_W]   = snap.minute;
    a_vec[PAT_POS   +: PAT_W]   = A_PATTERN;
    b_vec[B_PAR_YEAR] = ~^snap.year;
    b_vec[B_PAR_DATE] = ~^{snap.month, snap.day};
    b_vec[B_PAR_DOW]  = ~^snap.dow;
    b_vec[B_PAR_TIME] = ~^{snap.hour, snap.minute};
    b_vec[B_BST]      = snap.bst;
  end

  assign a_bit = a_vec[second];
  assign b_bit = b_vec[second];

endmodule

// File: rtl/msf_encoder.sv
// MSF 60 s time-code generator: carrier on/off keying paced by a 1 ms tick.
// Outputs registered, valid 1 clk after start_i / tick_ms_i / stop_i.
// No backpressure; start_i ignored while busy, stop_i aborts immediately.
module msf_encoder
  import msf_pkg::*;
#(
  parameter int SEG_TICKS = 100
) (
  input logic             clk_i,
  input logic             rst_i,
  msf_encoder_if.slave    bus
);

  localparam int              TW        = (SEG_TICKS > 1) ? $clog2(SEG_TICKS) : 1;
  localparam logic [TW-1:0]   LAST_TICK = TW'(SEG_TICKS - 1);
  localparam logic [3:0]      LAST_SEG  = 4'(SEGS_PER_SEC - 1);
  localparam logic [3:0]      MARK_SEGS = 4'(MARKER_SEGS);
  localparam logic [5:0]      LAST_SEC  = 6'(SECS_PER_MIN - 1);

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [3:0]    seg, seg_n;
  logic [5:0]    second, second_n;
  snap_t         snap, snap_n, live;
  logic          carrier, carrier_n;
  logic          mstart, mstart_n;
  logic          a_bit, b_bit;

  assign live = '{year:   bus.year_i,  month: bus.month_i, day:    bus.day_i,
                  dow:    bus.dow_i,   hour:  bus.hour_i,  minute: bus.minute_i,
                  bst:    bus.bst_i};

  // Bits are looked up for the second being entered so keying is ready on the edge
  msf_frame_bits u_bits (
    .second (second_n),
    .snap   (snap),
    .a_bit  (a_bit),
    .b_bit  (b_bit)
  );

  // Next-state, counter advance, snapshot capture and keying decision
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    seg_n     = seg;
    second_n  = second;
    snap_n    = snap;
    carrier_n = carrier;
    mstart_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        carrier_n = 1'b1;
        if (bus.start_i && !bus.stop_i) begin
          // A coinciding tick is swallowed: segment 0 gets a full SEG_TICKS
          state_n   = ST_RUN;
          tick_n    = '0;
          seg_n     = '0;
          second_n  = '0;
          snap_n    = live;
          mstart_n  = 1'b1;
          carrier_n = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.stop_i) begin
          state_n   = ST_IDLE;
          tick_n    = '0;
          seg_n     = '0;
          second_n  = '0;
          carrier_n = 1'b1;
        end else if (bus.tick_ms_i) begin
          if (tick_cnt == LAST_TICK) begin
            tick_n = '0;
            if (seg == LAST_SEG) begin
              seg_n = '0;
              if (second == LAST_SEC) begin
                // Continuous operation: wrap to a fresh minute with new inputs
                second_n = '0;
                snap_n   = live;
                mstart_n = 1'b1;
              end else begin
                second_n = second + 6'd1;
              end
            end else begin
              seg_n = seg + 4'd1;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
          if (second_n == 6'd0) begin
            carrier_n = (seg_n >= MARK_SEGS);
          end else begin
            carrier_n = !((seg_n == 4'd0) || (seg_n == 4'd1 && a_bit) ||
                          (seg_n == 4'd2 && b_bit));
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Counters, snapshot and keying registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
      seg      <= '0;
      second   <= '0;
      snap     <= '0;
      carrier  <= 1'b1;
      mstart   <= 1'b0;
    end else begin
      tick_cnt <= tick_n;
      seg      <= seg_n;
      second   <= second_n;
      snap     <= snap_n;
      carrier  <= carrier_n;
      mstart   <= mstart_n;
    end
  end

  assign bus.carrier_o      = carrier;
  assign bus.second_o       = second;
  assign bus.minute_start_o = mstart;
  assign bus.busy_o         = (state == ST_RUN);

endmodule

// File: tb/tb_msf_encoder.sv
// Randomised bench for msf_encoder against a tick-counting reference model.
// Model derives second/segment from the tick count since frame start.
// Tick spacing is randomised; inputs change mid-frame to exercise snapshotting.
module tb_msf_encoder;

  localparam int ST        = 2;
  localparam int TPS       = 10 * ST;   // ticks per second
  localparam int TPM       = 60 * TPS;  // ticks per minute

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msf_encoder_if bus ();

  msf_encoder #(.SEG_TICKS(ST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         k;  // ticks since start of current minute
  logic [7:0] m_year;
  logic [4:0] m_month;
  logic [5:0] m_day;
  logic [2:0] m_dow;
  logic [5:0] m_hour;
  logic [6:0] m_minute;
  logic       m_bst;

  // Capture registers for field-level checks
  logic [7:0] cap_a;
  logic [4:0] cap_b;
  logic [3:0] cap54;

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit bit_of(int value, int pos);
    return ((value >> pos) & 1) == 1;
  endfunction

  function automatic bit ref_a(int s);
    if (s >= 17 && s <= 24) return bit_of(int'(m_year),   24 - s);
    if (s >= 25 && s <= 29) return bit_of(int'(m_month),  29 - s);
    if (s >= 30 && s <= 35) return bit_of(int'(m_day),    35 - s);
    if (s >= 36 && s <= 38) return bit_of(int'(m_dow),    38 - s);
    if (s >= 39 && s <= 44) return bit_of(int'(m_hour),   44 - s);
    if (s >= 45 && s <= 51) return bit_of(int'(m_minute), 51 - s);
    if (s >= 53 && s <= 58) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ref_b(int s);
    case (s)
      54: return ($countones(m_year) % 2) == 0;
      55: return (($countones(m_month) + $countones(m_day)) % 2) == 0;
      56: return ($countones(m_dow) % 2) == 0;
      57: return (($countones(m_hour) + $countones(m_minute)) % 2) == 0;
      58: return m_bst;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_carrier(int s, int g);
    if (s == 0) return g >= 5;
    return !(g == 0 || (g == 1 && ref_a(s)) || (g == 2 && ref_b(s)));
  endfunction

  task automatic latch_model();
    m_year   = bus.year_i;
    m_month  = bus.month_i;
    m_day    = bus.day_i;
    m_dow    = bus.dow_i;
    m_hour   = bus.hour_i;
    m_minute = bus.minute_i;
    m_bst    = bus.bst_i;
  endtask

  task automatic rand_inputs();
    bus.year_i   = to_bcd($urandom_range(0, 99));
    bus.month_i  = 5'(to_bcd($urandom_range(1, 12)));
    bus.day_i    = 6'(to_bcd($urandom_range(1, 31)));
    bus.dow_i    = 3'($urandom_range(0, 6));
    bus.hour_i   = 6'(to_bcd($urandom_range(0, 23)));
    bus.minute_i = 7'(to_bcd($urandom_range(0, 59)));
    bus.bst_i    = 1'($urandom_range(0, 1));
  endtask

  // One tick after a random idle gap; checks all outputs against the model
  task automatic do_tick();
    int s, g;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.tick_ms_i = 1'b1;
    @(negedge clk);
    bus.tick_ms_i = 1'b0;
    k++;
    if (k == TPM) begin
      k = 0;
      latch_model();
    end
    s = k / TPS;
    g = (k / ST) % 10;
    checks++;
    if (bus.second_o !== 6'(s)) begin
      errors++;
      $display("FAIL second k=%0d got %0d exp %0d", k, bus.second_o, s);
    end
    checks++;
    if (bus.carrier_o !== ref_carrier(s, g)) begin
      errors++;
      $display("FAIL carrier s=%0d seg=%0d got %b exp %b", s, g, bus.carrier_o, ref_carrier(s, g));
    end
    checks++;
    if (bus.minute_start_o !== (k == 0)) begin
      errors++;
      $display("FAIL minute_start k=%0d got %b exp %b", k, bus.minute_start_o, (k == 0));
    end
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_run k=%0d got %b exp 1", k, bus.busy_o);
    end
    if (g == 1 && s >= 17 && s <= 24) cap_a[24 - s] = bus.carrier_o;
    if (g == 2 && s >= 54 && s <= 58) cap_b[58 - s] = bus.carrier_o;
    if (s == 54 && g <= 3)            cap54[3 - g]  = bus.carrier_o;
  endtask

  task automatic start_frame(input bit with_tick);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.tick_ms_i = with_tick;
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.tick_ms_i = 1'b0;
    k = 0;
    latch_model();
    checks++;
    if (bus.busy_o !== 1'b1 || bus.second_o !== 6'd0 || bus.carrier_o !== 1'b0 ||
        bus.minute_start_o !== 1'b1) begin
      errors++;
      $display("FAIL start busy/sec/car/ms got %b/%0d/%b/%b exp 1/0/0/1",
               bus.busy_o, bus.second_o, bus.carrier_o, bus.minute_start_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tick_ms_i = 0; bus.start_i = 0; bus.stop_i = 0;
    bus.year_i = 0; bus.month_i = 0; bus.day_i = 0; bus.dow_i = 0;
    bus.hour_i = 0; bus.minute_i = 0; bus.bst_i = 0;
    #2;
    checks++;
    if (bus.carrier_o !== 1'b1 || bus.second_o !== 6'd0 || bus.busy_o !== 1'b0 ||
        bus.minute_start_o !== 1'b0) begin
      errors++;
      $display("FAIL reset car/sec/busy/ms got %b/%0d/%b/%b exp 1/0/0/0",
               bus.carrier_o, bus.second_o, bus.busy_o, bus.minute_start_o);
    end
    @(negedge clk);
    rst = 1'b0;
    // Ticks alone must not leave IDLE
    repeat (3) begin
      bus.tick_ms_i = 1'b1; @(negedge clk); bus.tick_ms_i = 1'b0;
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.carrier_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_ticks busy/car got %b/%b exp 0/1", bus.busy_o, bus.carrier_o);
    end
  endtask

  task automatic test_first_frame();
    logic [4:0] exp_b;
    bus.year_i = 8'h24; bus.month_i = 5'h03; bus.day_i = 6'h15; bus.dow_i = 3'd5;
    bus.hour_i = 6'h13; bus.minute_i = 7'h47; bus.bst_i = 1'b1;
    start_frame(1'b1);
    for (int s = 54; s <= 58; s++) exp_b[58 - s] = ref_b(s);
    for (int i = 1; i <= TPM; i++) begin
      if (i == TPM / 2) rand_inputs();
      do_tick();
    end
    checks++;
    if (~cap_a !== 8'b0010_0100) begin
      errors++;
      $display("FAIL year_bits got %b exp 00100100", ~cap_a);
    end
    checks++;
    if (~cap_b !== exp_b) begin
      errors++;
      $display("FAIL b54_58 got %b exp %b", ~cap_b, exp_b);
    end
    checks++;
    if (cap54 !== 4'b0001) begin
      errors++;
      $display("FAIL sec54_pattern got %b exp 0001", cap54);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= TPM; i++) begin
      if (i == TPM / 4 || i == TPM - 1) rand_inputs();
      do_tick();
    end
  endtask

  task automatic test_stop();
    repeat (30 * TPS + ST) do_tick();
    @(negedge clk);
    bus.stop_i = 1'b1; bus.start_i = 1'b1; bus.tick_ms_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0; bus.start_i = 1'b0; bus.tick_ms_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.carrier_o !== 1'b1 || bus.second_o !== 6'd0) begin
      errors++;
      $display("FAIL stop busy/car/sec got %b/%b/%0d exp 0/1/0",
               bus.busy_o, bus.carrier_o, bus.second_o);
    end
    repeat (4) begin
      bus.tick_ms_i = 1'b1; @(negedge clk); bus.tick_ms_i = 1'b0;
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.second_o !== 6'd0 || bus.minute_start_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays busy/sec/ms got %b/%0d/%b exp 0/0/0",
               bus.busy_o, bus.second_o, bus.minute_start_o);
    end
  endtask

  task automatic test_async_reset();
    rand_inputs();
    start_frame(1'b0);
    repeat (2 * TPS) do_tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.carrier_o !== 1'b1 || bus.second_o !== 6'd0 || bus.busy_o !== 1'b0 ||
        bus.minute_start_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset car/sec/busy/ms got %b/%0d/%b/%b exp 1/0/0/0",
               bus.carrier_o, bus.second_o, bus.busy_o, bus.minute_start_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.carrier_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset busy/car got %b/%b exp 0/1", bus.busy_o, bus.carrier_o);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
